// File: rtl/serial_feeder_pkg.sv
// Shared types and sizing helpers for the serial bit feeder.
// Defaults mirror the top-level parameter defaults.
package serial_feeder_pkg;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_DEPTH  = 4;
   localparam int unsigned CNT_W      = $clog2(DEF_DATA_W);
   localparam int unsigned PTR_W      = $clog2(DEF_DEPTH);

   // Width for a counter/pointer over n positions, never narrower than 1 bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_feeder_fifo.sv
// Synchronous word FIFO with registered occupancy count.
// Pushes while full and pops while empty are ignored.
module serial_feeder_fifo
   import serial_feeder_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         pop,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [width_of(DEPTH):0]     count
);

   localparam int unsigned PW = width_of(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/serial_bit_feeder.sv
// Buffers parallel words and shifts them out one bit per clock,
// with registered bit_valid/frame_start qualifiers for word alignment.
module serial_bit_feeder
   import serial_feeder_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 4,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      bit_out,
   output logic                      bit_valid,
   output logic                      frame_start,
   output logic                      busy,
   output logic [$clog2(DEPTH):0]    fifo_count
);

   localparam int unsigned      CW   = width_of(DATA_W);
   localparam logic [CW-1:0]    LAST = CW'(DATA_W - 1);

   state_t            state;
   state_t            state_nx;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nx;
   logic [CW-1:0]     bit_cnt;
   logic [CW-1:0]     bit_cnt_nx;
   logic [DATA_W-1:0] head;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              cur_bit_nx;

   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign busy     = (state == SHIFT) || !empty;

   serial_feeder_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (in_data),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (fifo_count)
   );

   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      bit_cnt_nx = bit_cnt;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shreg_nx   = head;
               bit_cnt_nx = '0;
               state_nx   = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_cnt == LAST) begin
               if (!empty) begin
                  pop        = 1'b1;
                  shreg_nx   = head;
                  bit_cnt_nx = '0;
               end else begin
                  state_nx   = IDLE;
               end
            end else begin
               shreg_nx   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
               bit_cnt_nx = bit_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign cur_bit_nx = MSB_FIRST ? shreg_nx[DATA_W-1] : shreg_nx[0];

   // Qualifiers are registered from next-state values so they line up
   // with the bit the shifter holds in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         bit_out     <= IDLE_BIT;
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nx;
         shreg       <= shreg_nx;
         bit_cnt     <= bit_cnt_nx;
         bit_valid   <= (state_nx == SHIFT);
         bit_out     <= (state_nx == SHIFT) ? cur_bit_nx : IDLE_BIT;
         frame_start <= (state_nx == SHIFT) && (bit_cnt_nx == '0);
      end
   end

endmodule
